// File: rtl/angle_sincos_cordic.sv
`default_nettype none
// ============================================================================
// Module   : angle_sincos_cordic
// Brief    : Iterative CORDIC turning a sprite angle into saturated sin/cos.
// Revision : 1.0
// ============================================================================
module angle_sincos_cordic #(
  parameter int ANGLE_W         = 9,
  parameter int SINCOS_FRACTION = 17,
  parameter int ITER            = 18,
  parameter int GUARD           = 3
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         start,
  input  logic [ANGLE_W-1:0]           angle,
  output logic                         busy,
  output logic                         done,
  output logic signed [SINCOS_FRACTION:0] sin_val,
  output logic signed [SINCOS_FRACTION:0] cos_val
);

  localparam int XY_W  = SINCOS_FRACTION + GUARD + 2;
  localparam int OUT_W = SINCOS_FRACTION + 1;
  localparam int IT_W  = (ITER > 1) ? $clog2(ITER) : 1;
  // Angle register: a full turn spans 2^Z_W codes, so 45 deg = 2^(Z_W-3).
  // The fine step keeps atan-table rounding well below one output LSB.
  localparam int Z_W   = 22;

  localparam real K_GAIN = 0.6072529;
  localparam logic signed [XY_W-1:0]  X_INIT  =
    XY_W'($rtoi(K_GAIN * (2.0 ** (SINCOS_FRACTION + GUARD)) + 0.5));
  localparam logic signed [OUT_W-1:0] OUT_MAX = OUT_W'(2 ** SINCOS_FRACTION - 1);
  localparam logic signed [XY_W:0]    SAT_MAX = (XY_W + 1)'(2 ** SINCOS_FRACTION - 1);
  localparam logic signed [XY_W:0]    SAT_MIN = -SAT_MAX;
  localparam logic signed [XY_W:0]    RND_BIAS = (XY_W + 1)'(1 << (GUARD - 1));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IT_W-1:0]           iter_q, iter_d;
  logic [1:0]                quad_q, quad_d;
  logic signed [XY_W-1:0]    x_q, x_d;
  logic signed [XY_W-1:0]    y_q, y_d;
  logic signed [Z_W-1:0]     z_q, z_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic signed [OUT_W-1:0]   sin_q, sin_d;
  logic signed [OUT_W-1:0]   cos_q, cos_d;

  logic signed [XY_W-1:0]    x_sh, y_sh;
  logic signed [Z_W-1:0]     atan_i;
  logic signed [XY_W-1:0]    cos_pre, sin_pre;

  // round(atan(2^-i) * 2^Z_W / (2*pi))
  function automatic logic signed [Z_W-1:0] atan_lut(input logic [IT_W-1:0] i);
    case (int'(i))
      0:       atan_lut = Z_W'(524288);
      1:       atan_lut = Z_W'(309505);
      2:       atan_lut = Z_W'(163534);
      3:       atan_lut = Z_W'(83012);
      4:       atan_lut = Z_W'(41667);
      5:       atan_lut = Z_W'(20854);
      6:       atan_lut = Z_W'(10430);
      7:       atan_lut = Z_W'(5215);
      8:       atan_lut = Z_W'(2608);
      9:       atan_lut = Z_W'(1304);
      10:      atan_lut = Z_W'(652);
      11:      atan_lut = Z_W'(326);
      12:      atan_lut = Z_W'(163);
      13:      atan_lut = Z_W'(81);
      14:      atan_lut = Z_W'(41);
      15:      atan_lut = Z_W'(20);
      16:      atan_lut = Z_W'(10);
      17:      atan_lut = Z_W'(5);
      default: atan_lut = Z_W'(667544 >> i);
    endcase
  endfunction

  // Drop guard bits with round-half-up, clamp symmetrically.
  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [XY_W-1:0] v);
    logic signed [XY_W:0] t;
    t = {v[XY_W-1], v} + RND_BIAS;
    t = t >>> GUARD;
    if (t > SAT_MAX) begin
      t = SAT_MAX;
    end else if (t < SAT_MIN) begin
      t = SAT_MIN;
    end
    round_sat = OUT_W'(t);
  endfunction

  always_comb begin
    x_sh   = x_q >>> iter_q;
    y_sh   = y_q >>> iter_q;
    atan_i = atan_lut(iter_q);
  end

  always_comb begin
    cos_pre = x_q;
    sin_pre = y_q;
    case (quad_q)
      2'd1: begin cos_pre = -y_q; sin_pre = x_q;  end
      2'd2: begin cos_pre = -x_q; sin_pre = -y_q; end
      2'd3: begin cos_pre = y_q;  sin_pre = -x_q; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    quad_d  = quad_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sin_d   = sin_q;
    cos_d   = cos_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          quad_d  = angle[ANGLE_W-1 -: 2];
          x_d     = X_INIT;
          y_d     = '0;
          z_d     = signed'({2'b00, angle[ANGLE_W-3:0], {(Z_W-ANGLE_W){1'b0}}});
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (!z_q[Z_W-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        iter_d = iter_q + 1'b1;
        if (iter_q == IT_W'(ITER - 1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        cos_d   = round_sat(cos_pre);
        sin_d   = round_sat(sin_pre);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      quad_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sin_q   <= '0;
      cos_q   <= OUT_MAX;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      quad_q  <= quad_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sin_val = sin_q;
  assign cos_val = cos_q;

endmodule
`default_nettype wire

// File: tb/tb_angle_sincos_cordic.sv
`default_nettype none
// ============================================================================
// Module   : tb_angle_sincos_cordic
// Brief    : Directed bench with a real-arithmetic sin/cos reference model.
// Revision : 1.0
// ============================================================================
module tb_angle_sincos_cordic;

  localparam int  ITER = 18;
  localparam int  TOL  = 8;
  localparam real PI   = 3.14159265358979;

  logic               clk;
  logic               resetN;
  logic               start;
  logic [8:0]         angle;
  logic               busy;
  logic               done;
  logic signed [17:0] sin_val;
  logic signed [17:0] cos_val;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  // Reference model state
  int         m_cnt   = 0;
  bit         m_done  = 1'b0;
  int         m_sin   = 0;
  int         m_cos   = 131071;
  logic [8:0] m_angle = '0;

  angle_sincos_cordic dut (
    .clk     (clk),
    .resetN  (resetN),
    .start   (start),
    .angle   (angle),
    .busy    (busy),
    .done    (done),
    .sin_val (sin_val),
    .cos_val (cos_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp_v, input int tol);
    checks++;
    if ((act - exp_v > tol) || (exp_v - act > tol)) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d tol=%0d t=%0t", name, act, exp_v, tol, $time);
    end
  endtask

  function automatic int ideal(input int a, input bit want_sin);
    real th, v;
    th = 2.0 * PI * real'(a) / 512.0;
    v  = want_sin ? $sin(th) : $cos(th);
    return $rtoi($floor(v * 131072.0 + 0.5));
  endfunction

  // Transaction-level model: an accepted request occupies the block for
  // ITER+1 clocks and the result appears with the final clock.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_sin  = 0;
      m_cos  = 131071;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 1) begin
        m_done = 1'b1;
        m_sin  = ideal(int'(m_angle), 1'b1);
        m_cos  = ideal(int'(m_angle), 1'b0);
      end
      if (m_cnt > 0) begin
        m_cnt--;
      end else if (start) begin
        m_angle = angle;
        m_cnt   = ITER + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_cnt > 0), 0);
    check("done", int'(done), int'(m_done), 0);
    check("sin_model", int'(sin_val), m_sin, TOL);
    check("cos_model", int'(cos_val), m_cos, TOL);
    if (sin_val == -18'sd131072 || cos_val == -18'sd131072) begin
      failures++;
      $display("FAIL neg_full_scale sin=%0d cos=%0d required>=-131071", sin_val, cos_val);
    end
    if (done) done_seen++;
  end

  task automatic run_one(input int a, output int lat, output int s, output int c);
    @(negedge clk);
    angle = 9'(a);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      failures++;
      $display("FAIL done_timeout angle=%0d waited=%0d", a, lat);
    end
    s = int'(sin_val);
    c = int'(cos_val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s, c;
    int nbusy, ndone, ds, dc, first_d, second_d, base;

    resetN = 1'b0;
    start  = 1'b0;
    angle  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_sin", int'(sin_val), 0, 0);
    check("rst_cos", int'(cos_val), 131071, 0);
    resetN = 1'b1;
    @(negedge clk);

    // Axis and diagonal angles
    run_one(0, lat, s, c);
    check("a0_latency", lat, 19, 0);
    check("a0_cos", c, 131071, TOL);
    check("a0_sin", s, 0, TOL);
    run_one(128, lat, s, c);
    check("a128_sin", s, 131071, TOL);
    check("a128_cos", c, 0, TOL);
    run_one(256, lat, s, c);
    check("a256_cos", c, -131071, TOL);
    check("a256_sin", s, 0, TOL);
    run_one(64, lat, s, c);
    check("a64_sin", s, 92682, TOL);
    check("a64_cos", c, 92682, TOL);
    run_one(448, lat, s, c);
    check("a448_cos", c, 92682, TOL);
    check("a448_sin", s, -92682, TOL);

    // Second start while busy is ignored
    @(negedge clk);
    angle = 9'd64;
    start = 1'b1;
    @(posedge clk);
    nbusy = 0; ndone = 0; ds = 0; dc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin ndone++; ds = int'(sin_val); dc = int'(cos_val); end
      if (k == 4) begin angle = 9'd200; start = 1'b1; end
      if (k == 5) start = 1'b0;
    end
    check("busy_ignore_dones", ndone, 1, 0);
    check("busy_ignore_len", nbusy, 19, 0);
    check("busy_ignore_sin", ds, 92682, TOL);
    check("busy_ignore_cos", dc, 92682, TOL);

    // Held start restarts every ITER+2 clocks; async reset aborts
    @(negedge clk);
    angle = 9'd32;
    start = 1'b1;
    first_d = -1; second_d = -1; ds = 0; dc = 0;
    for (int k = 0; k < 60 && second_d < 0; k++) begin
      @(negedge clk);
      if (done) begin
        if (first_d < 0) begin first_d = k; ds = int'(sin_val); dc = int'(cos_val); end
        else second_d = k;
      end
    end
    check("held_period", second_d - first_d, 20, 0);
    check("a32_sin", ds, 50159, TOL);
    check("a32_cos", dc, 121096, TOL);
    @(posedge clk);
    repeat (7) @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_done", int'(done), 0, 0);
    check("abort_sin", int'(sin_val), 0, 0);
    check("abort_cos", int'(cos_val), 131071, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    base = done_seen;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_seen - base, 0, 0);

    // Back-to-back sweep of every angle
    base = done_seen;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      angle = 9'(k);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
    end
    lat = 0;
    while (done_seen - base < 512 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("sweep_dones", done_seen - base, 512, 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
